// File: rtl/i2c_cmd_queue_if.sv
// Bundles the software-facing command/response FIFO signals and the
// i2c_controller strobe/status pair seen by the command sequencer.
interface i2c_cmd_queue_if #(
  parameter int C_DEPTH_LOG2 = 3
);
  logic                    cmd_push_i;
  logic [10:0]             cmd_data_i;
  logic                    cmd_full_o;
  logic [C_DEPTH_LOG2:0]   cmd_count_o;
  logic                    overflow_o;
  logic                    flush_i;
  logic                    rsp_pop_i;
  logic [8:0]              rsp_data_o;
  logic                    rsp_valid_o;
  logic                    idle_o;
  logic                    i2c_cmd_pulse_o;
  logic [10:0]             i2c_ctrl_reg_o;
  logic [9:0]              i2c_status_reg_i;

  modport master (
    output cmd_push_i, cmd_data_i, flush_i, rsp_pop_i, i2c_status_reg_i,
    input  cmd_full_o, cmd_count_o, overflow_o, rsp_data_o, rsp_valid_o,
           idle_o, i2c_cmd_pulse_o, i2c_ctrl_reg_o
  );

  modport slave (
    input  cmd_push_i, cmd_data_i, flush_i, rsp_pop_i, i2c_status_reg_i,
    output cmd_full_o, cmd_count_o, overflow_o, rsp_data_o, rsp_valid_o,
           idle_o, i2c_cmd_pulse_o, i2c_ctrl_reg_o
  );
endinterface

// File: rtl/i2c_cmd_queue.sv
// Command sequencer: queues I2C command words, issues them one at a time to
// i2c_controller and collects one 9-bit result per command.
module i2c_cmd_queue #(
  parameter int C_DEPTH_LOG2 = 3
) (
  input  logic            clk,
  input  logic            rst,
  i2c_cmd_queue_if.slave  bus
);
  localparam int DEPTH = 1 << C_DEPTH_LOG2;
  localparam int PW    = C_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] cmd_wr_reg, cmd_wr_next, cmd_rd_reg, cmd_rd_next;
  logic [PW-1:0] rsp_wr_reg, rsp_wr_next, rsp_rd_reg, rsp_rd_next;
  logic          overflow_reg, overflow_next;
  logic [10:0]   ctrl_reg;
  logic [10:0]   cmd_mem [DEPTH];
  logic [8:0]    rsp_mem [DEPTH];

  logic cmd_empty, cmd_full, rsp_empty, rsp_full;
  logic push_ok, issue, done, busy;

  assign busy      = bus.i2c_status_reg_i[9];
  assign cmd_empty = (cmd_wr_reg == cmd_rd_reg);
  assign cmd_full  = (cmd_wr_reg[C_DEPTH_LOG2-1:0] == cmd_rd_reg[C_DEPTH_LOG2-1:0]) &&
                     (cmd_wr_reg[C_DEPTH_LOG2] != cmd_rd_reg[C_DEPTH_LOG2]);
  assign rsp_empty = (rsp_wr_reg == rsp_rd_reg);
  assign rsp_full  = (rsp_wr_reg[C_DEPTH_LOG2-1:0] == rsp_rd_reg[C_DEPTH_LOG2-1:0]) &&
                     (rsp_wr_reg[C_DEPTH_LOG2] != rsp_rd_reg[C_DEPTH_LOG2]);
  assign push_ok   = bus.cmd_push_i && !cmd_full && !bus.flush_i;

  // Issue only with a free response slot so the result always has a home.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!cmd_empty && !rsp_full && !bus.flush_i) begin
          state_next = ISSUE;
          issue      = 1'b1;
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (busy) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (!busy) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  // Flush keeps only the entry the controller is currently working on.
  always_comb begin
    cmd_rd_next   = cmd_rd_reg + (done ? PTR_ONE : PTR_ZERO);
    cmd_wr_next   = cmd_wr_reg + (push_ok ? PTR_ONE : PTR_ZERO);
    overflow_next = overflow_reg || (bus.cmd_push_i && cmd_full);
    rsp_rd_next   = rsp_rd_reg + ((bus.rsp_pop_i && !rsp_empty) ? PTR_ONE : PTR_ZERO);
    rsp_wr_next   = rsp_wr_reg + (done ? PTR_ONE : PTR_ZERO);
    if (bus.flush_i) begin
      cmd_wr_next   = cmd_rd_reg + ((state_reg != IDLE) ? PTR_ONE : PTR_ZERO);
      overflow_next = 1'b0;
      rsp_rd_next   = rsp_wr_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cmd_wr_reg   <= '0;
      cmd_rd_reg   <= '0;
      rsp_wr_reg   <= '0;
      rsp_rd_reg   <= '0;
      overflow_reg <= 1'b0;
      ctrl_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cmd_wr_reg   <= cmd_wr_next;
      cmd_rd_reg   <= cmd_rd_next;
      rsp_wr_reg   <= rsp_wr_next;
      rsp_rd_reg   <= rsp_rd_next;
      overflow_reg <= overflow_next;
      if (issue) ctrl_reg <= cmd_mem[cmd_rd_reg[C_DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) cmd_mem[cmd_wr_reg[C_DEPTH_LOG2-1:0]] <= bus.cmd_data_i;
    if (done)    rsp_mem[rsp_wr_reg[C_DEPTH_LOG2-1:0]] <= bus.i2c_status_reg_i[8:0];
  end

  assign bus.cmd_full_o      = cmd_full;
  assign bus.cmd_count_o     = cmd_wr_reg - cmd_rd_reg;
  assign bus.overflow_o      = overflow_reg;
  assign bus.rsp_valid_o     = !rsp_empty;
  assign bus.rsp_data_o      = rsp_empty ? 9'h000 : rsp_mem[rsp_rd_reg[C_DEPTH_LOG2-1:0]];
  assign bus.idle_o          = (state_reg == IDLE) && cmd_empty;
  assign bus.i2c_cmd_pulse_o = (state_reg == ISSUE);
  assign bus.i2c_ctrl_reg_o  = ctrl_reg;
endmodule
